// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// State encoding, default requester count and index-width helper.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam int DEFAULT_N = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set req bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_priority_pick
    import rr_sched_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] winner
);

    int idx;

    // Walk the requesters in rotation order starting at ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: registered one-hot grant, bounded hold,
// one dead cycle between grants. Optional watchdog: RR_SCHED_TIMEOUT_EN.
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [N-1:0]            req,
    output logic [N-1:0]            grant,
    output logic                    grant_valid,
    output logic [idx_width(N)-1:0] grant_id,
    output logic                    timeout_err
);

    localparam int W  = idx_width(N);
    localparam int HW = idx_width(MAX_HOLD);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [W-1:0]  LAST_ID   = W'(N - 1);

    state_t          state;
    logic [W-1:0]    ptr;
    logic [HW-1:0]   hold_cnt;
    logic            found;
    logic [W-1:0]    winner;
    logic [W-1:0]    next_ptr;
    logic            force_rel;
    logic            release_now;

    rr_priority_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    assign grant_valid = |grant;
    assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + W'(1);
    assign release_now = !req[grant_id]
                       || (hold_cnt == HOLD_LAST)
                       || force_rel;

`ifdef RR_SCHED_TIMEOUT_EN
    localparam int CW = idx_width(TIMEOUT);

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt;

    // The TIMEOUT-th consecutive busy cycle cuts the grant short
    assign force_rel = grant_valid && (wd_cnt == TO_LAST);

    // Watchdog: busy cycles accumulate across GAP, clear in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (force_rel) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
        end else if (grant_valid) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign force_rel      = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                GRANT: begin
                    if (release_now) begin
                        grant    <= '0;
                        ptr      <= next_ptr;
                        hold_cnt <= '0;
                        state    <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                IDLE, GAP: begin
                    if (go && found) begin
                        grant    <= N'(1) << winner;
                        grant_id <= winner;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    grant    <= '0;
                    hold_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with an expected-grant queue.
// With RR_SCHED_TIMEOUT_EN defined it runs the watchdog sequence instead.
module tb_rr_grant_scheduler;

    localparam int N  = 8;
    localparam int MH = 16;
    localparam int TO = 20;

    logic         clk;
    logic         reset;
    logic         go;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_id;
    logic         timeout_err;

    typedef struct packed {
        logic [N-1:0] g;
        logic         e;
    } exp_t;

    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;
    int drain_cnt  = 0;
    int wait7      = -1;

    rr_grant_scheduler #(
        .N        (N),
        .MAX_HOLD (MH),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic int bit_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    task automatic push(input logic [N-1:0] g, input int n,
                        input logic e = 1'b0);
        exp_t x;
        x.g = g;
        x.e = e;
        for (int i = 0; i < n; i++) sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        exp_t x;
        drain_cnt = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            x = sb.pop_front();
            drain_cnt++;
            if (grant[7] && wait7 < 0) wait7 = drain_cnt;
            chk({tag, ".grant"}, 32'(grant), 32'(x.g));
            chk({tag, ".valid"}, 32'(grant_valid), 32'(|x.g));
            chk({tag, ".terr"}, 32'(timeout_err), 32'(x.e));
            if (x.g != '0) begin
                chk({tag, ".id"}, 32'(grant_id), 32'(bit_idx(x.g)));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.valid", 32'(grant_valid), 32'h0);
        chk("rst.id", 32'(grant_id), 32'h0);
        chk("rst.terr", 32'(timeout_err), 32'h0);
        reset = 1'b0;

`ifdef RR_SCHED_TIMEOUT_EN
        go  = 1'b1;
        req = 8'h03;
        push(8'h01, 16);
        push(8'h00, 1);
        push(8'h02, 4);
        push(8'h00, 1, 1'b1);
        push(8'h01, 5, 1'b1);
        drain("wdog");
        req = 8'h00;
        push(8'h00, 3, 1'b1);
        drain("wdog_idle");
`else
        go  = 1'b1;
        req = 8'h00;
        push(8'h00, 3);
        drain("noreq");

        req = 8'h81;
        push(8'h01, 16);
        push(8'h00, 1);
        push(8'h80, 16);
        push(8'h00, 1);
        push(8'h01, 1);
        drain("pair");
        req = 8'h00;
        push(8'h00, 2);
        drain("pair_end");

        req = 8'h04;
        push(8'h04, 3);
        drain("pulse");
        req = 8'h00;
        push(8'h00, 2);
        drain("pulse_end");
        req = 8'h0C;
        push(8'h08, 16);
        push(8'h00, 1);
        push(8'h04, 1);
        drain("ptr3");
        req = 8'h00;
        push(8'h00, 2);
        drain("ptr3_end");

        reset = 1'b1;
        #2;
        reset = 1'b0;
        req   = 8'hFF;
        wait7 = -1;
        for (int i = 0; i < 8; i++) begin
            push(8'(1 << i), MH);
            push(8'h00, 1);
        end
        push(8'h01, 1);
        drain("rotate");
        chk("fair.wait7", 32'(wait7 > 0 && wait7 <= 7 * 17 + 2), 32'h1);

        reset = 1'b1;
        #1;
        chk("async.grant", 32'(grant), 32'h0);
        chk("async.valid", 32'(grant_valid), 32'h0);
        chk("async.id", 32'(grant_id), 32'h0);
        #1;
        reset = 1'b0;
        push(8'h01, 1);
        drain("post_rst");

        req = 8'h03;
        go  = 1'b0;
        push(8'h01, MH - 1);
        push(8'h00, 5);
        drain("go_low");
        go = 1'b1;
        push(8'h02, 1);
        drain("go_back");
        req = 8'h00;
        push(8'h00, 2);
        drain("final");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
